// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the multi-cycle PC sequencer: phase encodings,
// default vectors and the next-PC source selector.
package pc_sequencer_pkg;

    // One-hot phase encodings; HALT is the all-zero word so that every
    // datapath unit qualifying on a single bit sees itself as idle.
    localparam logic [5:0] STATE_FETCH   = 6'b000001;
    localparam logic [5:0] STATE_DECODE  = 6'b000010;
    localparam logic [5:0] STATE_EXECUTE = 6'b000100;
    localparam logic [5:0] STATE_MEM     = 6'b001000;
    localparam logic [5:0] STATE_WB      = 6'b010000;
    localparam logic [5:0] STATE_PCUPD   = 6'b100000;
    localparam logic [5:0] STATE_HALT    = 6'b000000;

    typedef enum logic [5:0] {
        ST_FETCH   = STATE_FETCH,
        ST_DECODE  = STATE_DECODE,
        ST_EXECUTE = STATE_EXECUTE,
        ST_MEM     = STATE_MEM,
        ST_WB      = STATE_WB,
        ST_PCUPD   = STATE_PCUPD,
        ST_HALT    = STATE_HALT
    } seq_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } next_pc_sel_e;

    // Sign-extended word offset converted to a byte displacement.
    function automatic logic [31:0] branch_disp(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the sequencer and the decoder / PC unit / memories.
// The sequencer side takes the master modport.
interface pc_sequencer_if;

    // memory handshake
    logic        imem_ready;
    logic        dmem_ready;
    logic        fetch_req;
    logic        mem_req;

    // decoded instruction attributes
    logic        needs_mem;
    logic        needs_wb;
    logic        is_branch;
    logic        branch_taken;
    logic        is_jump;
    logic        is_jr;
    logic [15:0] branch_off;
    logic [25:0] jump_tgt;
    logic [31:0] jr_tgt;
    logic        halt;

    // sequencer outputs
    logic [5:0]  state;
    logic [31:0] pc_in;
    logic        pc_enable;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misalign;
    logic [31:0] retired;

    modport master (
        input  imem_ready, dmem_ready,
        input  needs_mem, needs_wb, is_branch, branch_taken, is_jump, is_jr,
        input  branch_off, jump_tgt, jr_tgt, halt,
        output fetch_req, mem_req,
        output state, pc_in, pc_enable, pc_plus4, halted, misalign, retired
    );

    modport slave (
        output imem_ready, dmem_ready,
        output needs_mem, needs_wb, is_branch, branch_taken, is_jump, is_jr,
        output branch_off, jump_tgt, jr_tgt, halt,
        input  fetch_req, mem_req,
        input  state, pc_in, pc_enable, pc_plus4, halted, misalign, retired
    );

endinterface

// File: rtl/pc_sequencer_next_pc_unit.sv
// Combinational next-PC selection: picks the target source by priority,
// forms branch/jump addresses and substitutes the exception vector for
// any target that is not word aligned.
module pc_sequencer_next_pc_unit
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic [31:0] pc_plus4_i,
    input  logic        is_jr_i,
    input  logic        is_jump_i,
    input  logic        is_branch_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_off_i,
    input  logic [25:0] jump_tgt_i,
    input  logic [31:0] jr_tgt_i,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    next_pc_sel_e sel;
    logic [31:0]  raw_target;

    // Priority select jr > jump > taken branch > sequential, then alignment check.
    always_comb begin
        sel        = NPC_SEQ;
        raw_target = pc_plus4_i;
        if (is_jr_i) begin
            sel = NPC_JR;
        end else if (is_jump_i) begin
            sel = NPC_J;
        end else if (is_branch_i && branch_taken_i) begin
            sel = NPC_BR;
        end

        case (sel)
            NPC_JR:  raw_target = jr_tgt_i;
            NPC_J:   raw_target = {pc_plus4_i[31:28], jump_tgt_i, 2'b00};
            NPC_BR:  raw_target = pc_plus4_i + branch_disp(branch_off_i);
            default: raw_target = pc_plus4_i;
        endcase

        // Branch and jump targets are aligned by construction, so in practice
        // only a register-sourced jr target can trip this.
        misalign_o = |raw_target[1:0];
        target_o   = misalign_o ? EXC_VECTOR : raw_target;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer for the non-pipelined core. Owns the
// architectural PC, the one-hot phase bus, the retired-instruction counter
// and the memory request strobes.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic             clk,
    input  logic             reset,
    pc_sequencer_if.master   bus
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] retired_q, retired_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        target_misalign;

    assign pc_plus4 = pc_q + 32'd4;

    pc_sequencer_next_pc_unit #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc (
        .pc_plus4_i     (pc_plus4),
        .is_jr_i        (bus.is_jr),
        .is_jump_i      (bus.is_jump),
        .is_branch_i    (bus.is_branch),
        .branch_taken_i (bus.branch_taken),
        .branch_off_i   (bus.branch_off),
        .jump_tgt_i     (bus.jump_tgt),
        .jr_tgt_i       (bus.jr_tgt),
        .target_o       (target),
        .misalign_o     (target_misalign)
    );

    // Next-state logic: phase transitions, next-PC capture and PC commit.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        retired_d  = retired_q;
        misalign_d = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                npc_d      = target;
                misalign_d = target_misalign;
                if (bus.needs_mem) begin
                    state_d = ST_MEM;
                end else if (bus.needs_wb) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_PCUPD;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    state_d = bus.needs_wb ? ST_WB : ST_PCUPD;
                end
            end
            ST_WB: begin
                state_d = ST_PCUPD;
            end
            ST_PCUPD: begin
                pc_d      = npc_q;
                retired_d = retired_q + 32'd1;
                state_d   = bus.halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                // Corrupted encodings restart the instruction at the current PC.
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_VECTOR;
            npc_q      <= RESET_VECTOR + 32'd4;
            retired_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            retired_q  <= retired_d;
            misalign_q <= misalign_d;
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free.
    assign bus.state     = state_q;
    assign bus.pc_in     = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.pc_enable = (state_q == ST_FETCH);
    assign bus.fetch_req = (state_q == ST_FETCH);
    assign bus.mem_req   = (state_q == ST_MEM);
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.misalign  = misalign_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: phase sequencing, wait states, next-PC
// sources, misalignment, wrap-around, halt and reset recovery.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] exp_retired = 32'd0;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h8000_0180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_ready = 0; bus.dmem_ready = 0; bus.needs_mem = 0; bus.needs_wb = 0;
        bus.is_branch = 0; bus.branch_taken = 0; bus.is_jump = 0; bus.is_jr = 0;
        bus.branch_off = '0; bus.jump_tgt = '0; bus.jr_tgt = '0; bus.halt = 0;
    endtask

    // Runs one zero-wait, non-memory instruction starting from a FETCH sample.
    // Returns the phase trace, the cycle count and the cycle index where
    // misalign was seen high (-1 if never).
    task automatic run_insn(input logic jr, input logic jmp, input logic br, input logic tk,
                            input logic wb, input logic hlt, input logic [15:0] off,
                            input logic [25:0] jt, input logic [31:0] jrt,
                            output logic [7:0][5:0] tr, output int ncyc, output int mis_at);
        tr = '0; ncyc = 0; mis_at = -1;
        bus.is_jr = jr; bus.is_jump = jmp; bus.is_branch = br; bus.branch_taken = tk;
        bus.needs_wb = wb; bus.halt = hlt; bus.branch_off = off; bus.jump_tgt = jt;
        bus.jr_tgt = jrt; bus.imem_ready = 1;
        do begin
            tr[ncyc] = bus.state;
            if (bus.misalign === 1'b1) mis_at = ncyc;
            step();
            bus.imem_ready = 0;
            ncyc++;
        end while (bus.state !== STATE_FETCH && bus.state !== STATE_HALT && ncyc < 8);
        clear_inputs();
        exp_retired++;
        $display("insn jr=%0b j=%0b br=%0b tk=%0b -> pc=%h cycles=%0d retired=%0d",
                 jr, jmp, br, tk, bus.pc_in, ncyc, bus.retired);
    endtask

    task automatic test_reset();
        reset = 0;
        step();
        n_checks++; if (bus.state !== STATE_FETCH) begin n_fail++; $display("FAIL reset_state: got %h want %h", bus.state, STATE_FETCH); end
        n_checks++; if (bus.pc_in !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc_in, 32'h0); end
        n_checks++; if (bus.pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h want %h", bus.pc_plus4, 32'h4); end
        n_checks++; if (bus.retired !== 32'h0) begin n_fail++; $display("FAIL reset_retired: got %h want 0", bus.retired); end
        n_checks++; if (bus.halted !== 1'b0 || bus.misalign !== 1'b0) begin n_fail++; $display("FAIL reset_flags: halted=%b misalign=%b want 0 0", bus.halted, bus.misalign); end
        n_checks++; if (bus.pc_enable !== 1'b1 || bus.fetch_req !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_reqs: en=%b freq=%b mreq=%b want 1 1 0", bus.pc_enable, bus.fetch_req, bus.mem_req); end
        reset = 1;
        exp_retired = 0;
        $display("reset -> state=%h pc=%h", bus.state, bus.pc_in);
    endtask

    task automatic test_alu();
        logic [5:0] exp_st [6] = '{STATE_FETCH, STATE_DECODE, STATE_EXECUTE, STATE_WB, STATE_PCUPD, STATE_FETCH};
        bus.needs_wb = 1; bus.imem_ready = 1;
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (bus.state !== exp_st[i]) begin n_fail++; $display("FAIL alu_state[%0d]: got %h want %h", i, bus.state, exp_st[i]); end
            n_checks++; if (bus.pc_enable !== (i == 0 || i == 5)) begin n_fail++; $display("FAIL alu_pc_enable[%0d]: got %b", i, bus.pc_enable); end
            if (i < 5) step();
        end
        clear_inputs();
        exp_retired++;
        n_checks++; if (bus.pc_in !== 32'h4) begin n_fail++; $display("FAIL alu_pc: got %h want %h", bus.pc_in, 32'h4); end
        n_checks++; if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL alu_retired: got %0d want %0d", bus.retired, exp_retired); end
        $display("alu insn -> pc=%h retired=%0d", bus.pc_in, bus.retired);
    endtask

    task automatic test_load_waits();
        // halt stays high until the PCUPD edge approaches; it must be ignored before then.
        bus.halt = 1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.state !== STATE_FETCH || bus.fetch_req !== 1'b1 || bus.pc_enable !== 1'b1) begin n_fail++; $display("FAIL load_fetch_hold[%0d]: state=%h freq=%b en=%b", i, bus.state, bus.fetch_req, bus.pc_enable); end
            if (i == 3) bus.imem_ready = 1;
            step();
        end
        bus.imem_ready = 0;
        n_checks++; if (bus.state !== STATE_DECODE || bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL load_decode: state=%h en=%b want %h 0", bus.state, bus.pc_enable, STATE_DECODE); end
        bus.needs_mem = 1; bus.needs_wb = 1;
        step();
        n_checks++; if (bus.state !== STATE_EXECUTE) begin n_fail++; $display("FAIL load_execute: got %h want %h", bus.state, STATE_EXECUTE); end
        step();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.state !== STATE_MEM || bus.mem_req !== 1'b1 || bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL load_mem_hold[%0d]: state=%h mreq=%b en=%b", i, bus.state, bus.mem_req, bus.pc_enable); end
            if (i == 2) bus.dmem_ready = 1;
            step();
        end
        bus.dmem_ready = 0;
        n_checks++; if (bus.state !== STATE_WB || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL load_wb: state=%h mreq=%b want %h 0", bus.state, bus.mem_req, STATE_WB); end
        bus.halt = 0; bus.needs_mem = 0; bus.needs_wb = 0;
        step();
        n_checks++; if (bus.state !== STATE_PCUPD) begin n_fail++; $display("FAIL load_pcupd: got %h want %h", bus.state, STATE_PCUPD); end
        step();
        exp_retired++;
        n_checks++; if (bus.state !== STATE_FETCH || bus.pc_in !== 32'h8 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL load_commit: state=%h pc=%h halted=%b want 01 00000008 0", bus.state, bus.pc_in, bus.halted); end
        n_checks++; if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL load_retired: got %0d want %0d", bus.retired, exp_retired); end
        $display("load insn -> pc=%h retired=%0d", bus.pc_in, bus.retired);
    endtask

    task automatic test_branch();
        logic [7:0][5:0] tr; int ncyc; int mis;
        logic [3:0][5:0] exp4 = {STATE_PCUPD, STATE_EXECUTE, STATE_DECODE, STATE_FETCH};
        run_insn(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h100, tr, ncyc, mis);
        n_checks++; if (bus.pc_in !== 32'h100 || ncyc != 4) begin n_fail++; $display("FAIL jr_setup: pc=%h cyc=%0d want 00000100 4", bus.pc_in, ncyc); end
        run_insn(0, 0, 1, 1, 0, 0, 16'hFFFE, 26'h0, 32'h0, tr, ncyc, mis);
        n_checks++; if (bus.pc_in !== 32'h0FC) begin n_fail++; $display("FAIL branch_taken_pc: got %h want %h", bus.pc_in, 32'h0FC); end
        n_checks++; if (tr[3:0] !== exp4 || ncyc != 4) begin n_fail++; $display("FAIL branch_trace: got %h cyc=%0d want %h 4", tr[3:0], ncyc, exp4); end
        run_insn(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h100, tr, ncyc, mis);
        run_insn(0, 0, 1, 0, 0, 0, 16'hFFFE, 26'h0, 32'h0, tr, ncyc, mis);
        n_checks++; if (bus.pc_in !== 32'h104) begin n_fail++; $display("FAIL branch_not_taken_pc: got %h want %h", bus.pc_in, 32'h104); end
        n_checks++; if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL branch_retired: got %0d want %0d", bus.retired, exp_retired); end
    endtask

    task automatic test_jump();
        logic [7:0][5:0] tr; int ncyc; int mis;
        run_insn(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h1000, tr, ncyc, mis);
        run_insn(0, 1, 0, 0, 0, 0, 16'h0, 26'h3FFFFFF, 32'h0, tr, ncyc, mis);
        n_checks++; if (bus.pc_in !== 32'h0FFF_FFFC || ncyc != 4) begin n_fail++; $display("FAIL jump_pc: got %h cyc=%0d want 0ffffffc 4", bus.pc_in, ncyc); end
    endtask

    task automatic test_misalign();
        logic [7:0][5:0] tr; int ncyc; int mis;
        run_insn(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0000_0402, tr, ncyc, mis);
        n_checks++; if (bus.pc_in !== 32'h8000_0180) begin n_fail++; $display("FAIL misalign_pc: got %h want %h", bus.pc_in, 32'h8000_0180); end
        n_checks++; if (mis != 3) begin n_fail++; $display("FAIL misalign_pulse_cycle: got %0d want 3", mis); end
        n_checks++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse_width: got %b want 0", bus.misalign); end
    endtask

    task automatic test_priority();
        logic [7:0][5:0] tr; int ncyc; int mis;
        run_insn(1, 1, 1, 1, 0, 0, 16'h0010, 26'h40, 32'h200, tr, ncyc, mis);
        n_checks++; if (bus.pc_in !== 32'h200) begin n_fail++; $display("FAIL prio_jr: got %h want %h", bus.pc_in, 32'h200); end
        run_insn(0, 1, 1, 1, 0, 0, 16'h0010, 26'h40, 32'h0, tr, ncyc, mis);
        n_checks++; if (bus.pc_in !== 32'h100) begin n_fail++; $display("FAIL prio_jump: got %h want %h", bus.pc_in, 32'h100); end
    endtask

    task automatic test_wrap();
        logic [7:0][5:0] tr; int ncyc; int mis;
        run_insn(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'hFFFF_FFFC, tr, ncyc, mis);
        n_checks++; if (bus.pc_in !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4: pc=%h plus4=%h want fffffffc 00000000", bus.pc_in, bus.pc_plus4); end
        run_insn(0, 0, 0, 0, 1, 0, 16'h0, 26'h0, 32'h0, tr, ncyc, mis);
        n_checks++; if (bus.pc_in !== 32'h0 || ncyc != 5) begin n_fail++; $display("FAIL wrap_seq: pc=%h cyc=%0d want 00000000 5", bus.pc_in, ncyc); end
        n_checks++; if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL wrap_retired: got %0d want %0d", bus.retired, exp_retired); end
    endtask

    task automatic test_halt();
        logic [7:0][5:0] tr; int ncyc; int mis;
        run_insn(0, 0, 0, 0, 1, 1, 16'h0, 26'h0, 32'h0, tr, ncyc, mis);
        n_checks++; if (bus.state !== STATE_HALT || bus.halted !== 1'b1 || ncyc != 5) begin n_fail++; $display("FAIL halt_enter: state=%h halted=%b cyc=%0d want 00 1 5", bus.state, bus.halted, ncyc); end
        n_checks++; if (bus.fetch_req !== 1'b0 || bus.mem_req !== 1'b0 || bus.pc_enable !== 1'b0) begin n_fail++; $display("FAIL halt_reqs: freq=%b mreq=%b en=%b want 0 0 0", bus.fetch_req, bus.mem_req, bus.pc_enable); end
        n_checks++; if (bus.pc_in !== 32'h4 || bus.retired !== exp_retired) begin n_fail++; $display("FAIL halt_commit: pc=%h retired=%0d want 00000004 %0d", bus.pc_in, bus.retired, exp_retired); end
        bus.imem_ready = 1; bus.dmem_ready = 1; bus.needs_mem = 1; bus.is_jr = 1; bus.jr_tgt = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.state !== STATE_HALT || bus.pc_in !== 32'h4 || bus.retired !== exp_retired) begin n_fail++; $display("FAIL halt_hold[%0d]: state=%h pc=%h retired=%0d", i, bus.state, bus.pc_in, bus.retired); end
        end
        reset = 0;
        step();
        reset = 1;
        clear_inputs();
        exp_retired = 0;
        n_checks++; if (bus.state !== STATE_FETCH || bus.pc_in !== 32'h0 || bus.retired !== 32'h0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset: state=%h pc=%h retired=%0d halted=%b want 01 00000000 0 0", bus.state, bus.pc_in, bus.retired, bus.halted); end
        $display("halt then reset -> state=%h pc=%h", bus.state, bus.pc_in);
    endtask

    task automatic test_reset_mid_mem();
        logic [7:0][5:0] tr; int ncyc; int mis;
        run_insn(0, 0, 0, 0, 1, 0, 16'h0, 26'h0, 32'h0, tr, ncyc, mis);
        bus.imem_ready = 1;
        step();
        bus.imem_ready = 0; bus.needs_mem = 1;
        step();
        step();
        n_checks++; if (bus.state !== STATE_MEM || bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL store_mem: state=%h mreq=%b want 08 1", bus.state, bus.mem_req); end
        reset = 0;
        step();
        reset = 1;
        clear_inputs();
        exp_retired = 0;
        n_checks++; if (bus.state !== STATE_FETCH || bus.pc_in !== 32'h0 || bus.retired !== 32'h0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mem_reset: state=%h pc=%h retired=%0d mreq=%b want 01 00000000 0 0", bus.state, bus.pc_in, bus.retired, bus.mem_req); end
        $display("reset mid-MEM -> state=%h pc=%h", bus.state, bus.pc_in);
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_alu();
        test_load_waits();
        test_branch();
        test_jump();
        test_misalign();
        test_priority();
        test_wrap();
        test_halt();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control sequencer for the non-pipelined MIPS core. It owns the architectural PC register and drives the one-hot `state` bus that every datapath unit (program counter, register file, ALU, memories) qualifies on. In EXECUTE it computes the next PC (sequential, branch, jump, jump-register) and commits it in PCUPDATE. It drives `pc_in` and `pc_enable` into the program counter unit and handshakes with instruction and data memory through ready signals.

Parameters:
RESET_VECTOR, 32'h00000000, PC value loaded on reset
EXC_VECTOR, 32'h80000180, PC substituted when a computed target is misaligned

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
imem_ready  in  1  instruction fetch complete (instruction valid at decoder)
dmem_ready  in  1  data memory access complete
needs_mem  in  1  decoded instruction is a load/store
needs_wb  in  1  decoded instruction writes a register
is_branch  in  1  conditional branch
branch_taken  in  1  ALU condition result, valid in EXECUTE
is_jump  in  1  j/jal
is_jr  in  1  jr/jalr
branch_off  in  16  signed word offset
jump_tgt  in  26  jump target field
jr_tgt  in  32  register operand for jr
halt  in  1  decoded halt/syscall-stop
state  out  6  one-hot phase
pc_in  out  32  PC value presented to program counter unit
pc_enable  out  1  PC load enable
pc_plus4  out  32  current PC + 4 (for jal link)
fetch_req  out  1  instruction memory request
mem_req  out  1  data memory request
halted  out  1  core halted
misalign  out  1  one-cycle pulse on misaligned target
retired  out  32  retired instruction count

Behaviour:
- States, one-hot: FETCH=6'b000001, DECODE=000010, EXECUTE=000100, MEM=001000, WB=010000, PCUPD=100000. HALT encodes as 6'b000000.
- Reset (reset==0 at posedge) overrides everything, including mid-MEM or HALT:
  - state=FETCH, pc_q=RESET_VECTOR, npc_q=RESET_VECTOR+4, retired=0.
  - halted=0, misalign=0.
- FETCH:
  - fetch_req=1, pc_enable=1, pc_in=pc_q.
  - Stay in FETCH until imem_ready=1, then go to DECODE. Unbounded wait.
- DECODE: one cycle, then EXECUTE.
- EXECUTE: one cycle. Register npc_q using priority is_jr > is_jump > (is_branch & branch_taken) > sequential:
  - jr: jr_tgt.
  - jump: {pc_plus4[31:28], jump_tgt, 2'b00}.
  - branch: pc_plus4 + (sign-extended branch_off << 2), modulo 2^32.
  - sequential: pc_plus4, wraps FFFFFFFC -> 00000000.
- Next state after EXECUTE: needs_mem ? MEM : needs_wb ? WB : PCUPD.
- Misaligned target: if the selected target has [1:0]!=0:
  - npc_q=EXC_VECTOR.
  - misalign pulses high for the cycle after EXECUTE.
  - Only jr can produce this.
- MEM:
  - mem_req=1 while in MEM.
  - Wait for dmem_ready, then go to needs_wb ? WB : PCUPD.
  - dmem_ready outside MEM is ignored.
- WB: one cycle, then PCUPD.
- PCUPD:
  - pc_q<=npc_q; retired<=retired+1, wraps at 2^32.
  - Next state is HALT if halt=1, else FETCH.
- HALT:
  - state=0, halted=1, all requests 0, pc_enable=0.
  - Exits only via reset.
- Decoder inputs are sampled only in their qualifying state: needs_* in EXECUTE/MEM, halt in PCUPD.
- pc_enable is 0 in every state except FETCH. pc_in always equals pc_q.
- pc_plus4 = pc_q+4 (combinational).
- Minimum cycles per instruction:
  - ALU: 5 (F,D,E,WB,PCUPD).
  - Store: 5.
  - Load: 6.
  - Branch/jump: 4.
  - Each zero-wait ready adds nothing.

Decomposition:
- Shared package holds:
  - state one-hot localparams and STATE_HALT.
  - Default vectors.
  - next_pc_sel enum: SEQ, BR, J, JR.
- One natural sub-module: next_pc_unit. Combinational target select, sign-extend/shift, misalign check.
- The FSM, counters and registers stay in pc_sequencer.

Test Plan:
- Reset then ALU instruction, imem_ready=1 immediately:
  - state sequence 01,02,04,10,20,01.
  - pc goes 0 -> 4; retired=1.
- Load with imem_ready delayed 3 cycles and dmem_ready delayed 2:
  - FETCH held 4 cycles, MEM held 3, then WB.
  - pc_enable high only in FETCH.
- Branch taken, pc=0x100, off=16'hFFFE:
  - npc=0x0FC, no WB/MEM.
  - Not taken gives 0x104.
- jr with jr_tgt=0x00000402:
  - misalign pulse, pc becomes 0x80000180.
  - jump_tgt=0x3FFFFFF at pc=0x1000 gives 0x0FFFFFFC.
- Wrap cases:
  - pc=0xFFFFFFFC sequential gives 0x00000000.
  - retired at 0xFFFFFFFF increments to 0.
- halt=1 in PCUPD:
  - state=0, halted=1, inputs ignored.
  - reset low asserted mid-MEM or in HALT returns to FETCH at RESET_VECTOR on the next edge.
